conv_channel_accumulator: RTL and testbench
===========================================

Name: conv_channel_accumulator

Overview:
- Downstream consumer of the 3x3 MAC stage's per-pixel dot products.
- Sums MAC results across input channels for every output pixel of a plane, holding partial sums in an internal buffer.
- After the last channel of each pixel: adds bias, applies an arithmetic right shift, optional ReLU, and saturation.
- Emits one requantised output pixel per beat over a valid/ready stream towards the writeback stage.

Parameters:
- WID_IN, 32, signed width of incoming MAC result
- WID_ACC, 40, signed partial-sum width
- WID_BIAS, 32, signed bias width
- WID_OUT, 16, signed output pixel width
- AW, 10, pixel address width; buffer depth 2^AW

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  one-cycle pulse; latches cfg_* and bias, starts a plane
- cfg_num_ch  in  8  input channels per plane (0 treated as 1)
- cfg_num_pix  in  AW+1  pixels per plane, 1..2^AW (0 treated as 1)
- cfg_shift  in  5  arithmetic right-shift amount
- cfg_relu  in  1  1 = clamp negatives to 0
- bias  in  WID_BIAS  signed bias for the plane's output channel
- in_valid  in  1  MAC result valid
- in_data  in  WID_IN  signed MAC result
- in_ready  out  1  beat accepted when in_valid & in_ready
- out_valid  out  1  output pixel valid
- out_data  out  WID_OUT  signed output pixel
- out_ready  in  1  downstream accepts
- busy  out  1  plane in progress
- done  out  1  one-cycle pulse, plane complete

Behaviour:
- Reset: state IDLE; ch=0, pix=0; in_ready=0, out_valid=0, out_data=0, busy=0, done=0. Buffer contents are not reset; the first-channel write overwrites them.
- Reset mid-plane: aborts the plane immediately. No done pulse is generated, and any pending output is dropped.
- IDLE:
  - in_ready=0.
  - cfg_start latches the config and moves to ACCUM with ch=0, pix=0, busy=1.
- cfg_start while busy is ignored.
- Input ordering is channel-major: all pixels 0..N-1 of channel 0, then all pixels of channel 1, and so on.
- ACCUM, non-last channel (ch < num_ch-1):
  - in_ready=1.
  - On accept: buf[pix] <= (ch==0 ? 0 : buf[pix]) + sext(in_data).
- ACCUM, last channel:
  - in_ready = !out_valid | out_ready.
  - On accept: sum = (ch==0 ? 0 : buf[pix]) + sext(in_data) + sext(bias), computed at WID_ACC.
- Counter wrap: pix increments per accepted beat. At pix == num_pix-1 it wraps to 0 and ch increments.
- Requantise path, in order:
  - s = sum >>> cfg_shift (arithmetic, truncating toward -inf).
  - If cfg_relu and s < 0, s = 0.
  - Saturate to [-2^(WID_OUT-1), 2^(WID_OUT-1)-1].
- Output register:
  - The requantised value is registered into out_data with out_valid=1 one cycle after acceptance.
  - out_valid and out_data hold stable until out_ready.
  - Accept and drain in the same cycle is allowed, giving full throughput of 1 pixel/cycle.
- num_ch == 1: every beat is last-channel; the buffer is unused.
- Buffer: register array with combinational read at pix and write on accept. At most one access per pixel per cycle, so there is no read/write hazard.
- Completion:
  - After the last beat is accepted (last channel, pix = num_pix-1), the state goes to DRAIN and in_ready=0.
  - When the final output is handshaken, done pulses for 1 cycle, busy drops, and the state returns to IDLE.
  - done and busy=0 assert in the cycle after that handshake.
- in_valid while in IDLE or DRAIN is not accepted, because in_ready=0.
- Overflow of WID_ACC is not detected. Callers keep num_ch * 2^WID_IN within range.

Test Plan:
- Basic: num_ch=3, num_pix=4, shift=0, relu=0, bias=10. Inputs are pix+1 on every channel. -> outputs 13,16,19,22 in order, then a done pulse.
- Requantise: num_ch=1, num_pix=3, shift=2, relu=1, bias=0. Inputs -9, 7, 200000. -> outputs 0, 1, 32767.
- Negative saturation with truncation: relu=0, shift=1, input -70001. -> output -32768. Input -3. -> output -2.
- Backpressure: hold out_ready=0 for 5 cycles during the last channel. -> in_ready deasserts after one buffered output; out_data is stable; no beat is lost or duplicated; output order is preserved.
- Config edges:
  - cfg_num_ch=0, cfg_num_pix=0 -> a single beat behaves as num_ch=1, num_pix=1.
  - cfg_start while busy -> ignored; counts are unchanged.
- Reset mid-plane: assert rst during channel 1 of a 3-channel plane. -> outputs are cleared and there is no done pulse. A fresh plane afterwards produces correct sums.

Source files
------------

// File: rtl/conv_channel_accumulator.sv
// Channel accumulator for the 3x3 MAC stage: sums per-pixel dot products across
// input channels, then adds bias, shifts, applies optional ReLU and saturates each output pixel.
module conv_channel_accumulator #(
  parameter int WID_IN   = 32,
  parameter int WID_ACC  = 40,
  parameter int WID_BIAS = 32,
  parameter int WID_OUT  = 16,
  parameter int AW       = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [7:0]                 cfg_num_ch,
  input  logic [AW:0]                cfg_num_pix,
  input  logic [4:0]                 cfg_shift,
  input  logic                       cfg_relu,
  input  logic signed [WID_BIAS-1:0] bias,
  input  logic                       in_valid,
  input  logic signed [WID_IN-1:0]   in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [WID_OUT-1:0]  out_data,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [AW:0] ONE_PIX = {{AW{1'b0}}, 1'b1};
  localparam logic signed [WID_ACC-1:0] SAT_MAX =
    {{(WID_ACC-WID_OUT+1){1'b0}}, {(WID_OUT-1){1'b1}}};
  localparam logic signed [WID_ACC-1:0] SAT_MIN =
    {{(WID_ACC-WID_OUT+1){1'b1}}, {(WID_OUT-1){1'b0}}};

  state_t state, state_nxt;

  logic [7:0]                 num_ch;
  logic [AW:0]                num_pix;
  logic [4:0]                 shift;
  logic                       relu;
  logic signed [WID_BIAS-1:0] bias_r;
  logic [7:0]                 ch;
  logic [AW-1:0]              pix;

  logic signed [WID_ACC-1:0] mem [0:(1<<AW)-1];

  logic                      last_ch, last_pix, accept;
  logic signed [WID_ACC-1:0] in_ext, bias_ext, base, partial, sum, shifted;
  logic signed [WID_OUT-1:0] q;

  assign last_ch  = (ch == num_ch - 8'd1);
  assign last_pix = ({1'b0, pix} == num_pix - ONE_PIX);
  assign busy     = (state != IDLE);
  // Last channel may only take a beat when the output register is free or draining this cycle.
  assign in_ready = (state == ACCUM) && (!last_ch || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign in_ext   = {{(WID_ACC-WID_IN){in_data[WID_IN-1]}}, in_data};
  assign bias_ext = {{(WID_ACC-WID_BIAS){bias_r[WID_BIAS-1]}}, bias_r};
  assign base     = (ch == 8'd0) ? '0 : mem[pix];
  assign partial  = base + in_ext;
  assign sum      = partial + bias_ext;

  always_comb begin
    shifted = sum >>> shift;
    if (relu && shifted < 0) shifted = '0;
    if (shifted > SAT_MAX)      q = SAT_MAX[WID_OUT-1:0];
    else if (shifted < SAT_MIN) q = SAT_MIN[WID_OUT-1:0];
    else                        q = shifted[WID_OUT-1:0];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cfg_start) state_nxt = ACCUM;
      ACCUM:   if (accept && last_ch && last_pix) state_nxt = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      pix       <= '0;
      num_ch    <= 8'd1;
      num_pix   <= ONE_PIX;
      shift     <= '0;
      relu      <= 1'b0;
      bias_r    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && out_valid && out_ready;
      if (state == IDLE && cfg_start) begin
        num_ch  <= (cfg_num_ch == 8'd0) ? 8'd1 : cfg_num_ch;
        num_pix <= (cfg_num_pix == '0) ? ONE_PIX : cfg_num_pix;
        shift   <= cfg_shift;
        relu    <= cfg_relu;
        bias_r  <= bias;
        ch      <= '0;
        pix     <= '0;
      end else if (accept) begin
        if (last_pix) begin
          pix <= '0;
          ch  <= ch + 8'd1;
        end else begin
          pix <= pix + 1'b1;
        end
      end
      if (accept && last_ch) begin
        out_valid <= 1'b1;
        out_data  <= q;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Partial sums only; the last channel goes straight to the output path.
  always_ff @(posedge clk) begin
    if (accept && !last_ch) mem[pix] <= partial;
  end

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Randomised self-checking bench for conv_channel_accumulator against a
// per-pixel arithmetic reference model.
module tb_conv_channel_accumulator;
  localparam int AW = 10;

  logic               clk = 1'b0, rst = 1'b1, cfg_start = 1'b0;
  logic [7:0]         cfg_num_ch = '0;
  logic [AW:0]        cfg_num_pix = '0;
  logic [4:0]         cfg_shift = '0;
  logic               cfg_relu = 1'b0;
  logic signed [31:0] bias = '0;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data = '0;
  logic               in_ready, out_valid, out_ready = 1'b1, busy, done;
  logic signed [15:0] out_data;

  int checks = 0, fails = 0;
  int stim[$], got[$], exp_q[$];
  bit timeout, done_lag_ok;
  int proto_err, done_cnt;

  conv_channel_accumulator #(
    .WID_IN(32), .WID_ACC(40), .WID_BIAS(32), .WID_OUT(16), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_ch(cfg_num_ch),
    .cfg_num_pix(cfg_num_pix), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bias(bias), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Each output pixel: bias plus the sum over channels, shifted, optionally ReLU'd, clamped.
  function automatic void model(input int nch, input int npix, input int sh, input bit rl, input int b);
    int nc, np;
    longint acc;
    nc = (nch == 0) ? 1 : nch;
    np = (npix == 0) ? 1 : npix;
    exp_q.delete();
    for (int p = 0; p < np; p++) begin
      acc = longint'(b);
      for (int c = 0; c < nc; c++) acc += longint'(stim[c*np + p]);
      acc = acc >>> sh;
      if (rl && acc < 0) acc = 0;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
      exp_q.push_back(int'(acc));
    end
  endfunction

  // Drives one plane from stim, collects outputs into got, and counts protocol violations.
  task automatic run_plane(input int nch, input int npix, input int sh, input bit rl, input int b,
                           input int stall_mode, input bit gaps, input int restart_at);
    int idx, cyc, last_out, done_cyc, stall_left;
    bit prev_stall, stall_started, restarted;
    logic signed [15:0] prev_data;
    idx = 0; cyc = 0; last_out = -10; done_cyc = -1; stall_left = 0;
    prev_stall = 0; stall_started = 0; restarted = 0; prev_data = '0;
    got.delete(); proto_err = 0; done_cnt = 0; timeout = 0;
    @(negedge clk);
    cfg_num_ch = nch[7:0]; cfg_num_pix = npix[AW:0]; cfg_shift = sh[4:0];
    cfg_relu = rl; bias = b; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (idx < stim.size()) begin
        in_valid = !gaps || ($urandom_range(0, 3) != 0);
        in_data  = stim[idx];
      end else begin
        in_valid = 1'b1;
        in_data  = 32'sd12345;
      end
      case (stall_mode)
        1: out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (!stall_started && out_valid) begin stall_started = 1; stall_left = 5; end
          out_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: out_ready = 1'b1;
      endcase
      cfg_start = 1'b0;
      if (restart_at >= 0 && idx == restart_at && !restarted) begin
        restarted = 1; cfg_start = 1'b1; cfg_num_ch = 8'd1; cfg_num_pix = 1; bias = 999;
      end
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data)) proto_err++;
      if (out_valid && !out_ready && in_ready) proto_err++;
      if (idx >= stim.size() && in_ready) proto_err++;
      if (done) begin done_cnt++; done_cyc = cyc; if (busy) proto_err++; end
      if (out_valid && out_ready) begin got.push_back(int'(out_data)); last_out = cyc; end
      if (in_valid && in_ready && idx < stim.size()) idx++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    timeout = (done_cnt == 0);
    done_lag_ok = (done_cyc == last_out + 1);
    #1;
    if (done || busy) proto_err++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0 || out_data !== 16'sd0) begin
      fails++; $display("FAIL reset_in flags=%b data=%0d exp flags=0000 data=0", {in_ready, out_valid, busy, done}, out_data);
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b1; #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0) begin
      fails++; $display("FAIL reset_idle flags=%b exp=0000", {in_ready, out_valid, busy, done});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic;
    stim.delete();
    for (int c = 0; c < 3; c++) for (int p = 0; p < 4; p++) stim.push_back(p + 1);
    run_plane(3, 4, 0, 0, 10, 0, 0, -1);
    exp_q = '{13, 16, 19, 22};
    checks++; if (got.size() != 4) begin fails++; $display("FAIL basic_count got=%0d exp=4", got.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL basic_pix%0d got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
    checks++; if (timeout || done_cnt != 1 || !done_lag_ok || proto_err != 0) begin
      fails++; $display("FAIL basic_done done_cnt=%0d lag_ok=%0d proto_err=%0d exp 1/1/0", done_cnt, done_lag_ok, proto_err);
    end
  endtask

  task automatic test_requant;
    stim = '{-9, 7, 200000};
    run_plane(1, 3, 2, 1, 0, 0, 0, -1);
    exp_q = '{0, 1, 32767};
    checks++; if (got.size() != 3) begin fails++; $display("FAIL requant_count got=%0d exp=3", got.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL requant_pix%0d got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
    checks++; if (timeout || done_cnt != 1 || proto_err != 0) begin
      fails++; $display("FAIL requant_done done_cnt=%0d proto_err=%0d exp 1/0", done_cnt, proto_err);
    end
  endtask

  task automatic test_neg_sat;
    stim = '{-70001, -3};
    run_plane(1, 2, 1, 0, 0, 0, 0, -1);
    exp_q = '{-32768, -2};
    checks++; if (got.size() != 2) begin fails++; $display("FAIL negsat_count got=%0d exp=2", got.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL negsat_pix%0d got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(int'($urandom_range(0, 20000)) - 10000);
    model(2, 6, 0, 0, -77);
    run_plane(2, 6, 0, 0, -77, 2, 0, -1);
    checks++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL bp_pix%0d got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
    checks++; if (proto_err != 0) begin fails++; $display("FAIL bp_protocol got=%0d violations exp=0", proto_err); end
    checks++; if (timeout || done_cnt != 1 || !done_lag_ok) begin
      fails++; $display("FAIL bp_done done_cnt=%0d lag_ok=%0d exp 1/1", done_cnt, done_lag_ok);
    end
  endtask

  task automatic test_cfg_edges;
    stim = '{5};
    run_plane(0, 0, 0, 0, 3, 0, 0, -1);
    checks++; if (got.size() != 1 || (got.size() == 1 && got[0] !== 8)) begin
      fails++; $display("FAIL cfg_zero got_n=%0d got0=%0d exp n=1 val=8", got.size(), (got.size() > 0) ? got[0] : 0);
    end
    checks++; if (timeout || done_cnt != 1 || proto_err != 0) begin
      fails++; $display("FAIL cfg_zero_done done_cnt=%0d proto_err=%0d exp 1/0", done_cnt, proto_err);
    end
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(int'($urandom_range(0, 1000)));
    model(2, 3, 0, 0, 5);
    run_plane(2, 3, 0, 0, 5, 0, 0, 2);
    checks++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL busy_start_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL busy_start_pix%0d got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    int nch, npix, sh, b;
    bit rl;
    for (int t = 0; t < 4; t++) begin
      nch = $urandom_range(1, 4); npix = $urandom_range(1, 40);
      sh = $urandom_range(10, 24); rl = 1'($urandom_range(0, 1)); b = int'($urandom);
      stim.delete();
      for (int i = 0; i < nch*npix; i++) stim.push_back(int'($urandom));
      model(nch, npix, sh, rl, b);
      run_plane(nch, npix, sh, rl, b, 1, 1, -1);
      checks++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
        checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_pix%0d got=%0d exp=%0d", t, i, got[i], exp_q[i]); end
      end
      checks++; if (timeout || done_cnt != 1 || !done_lag_ok || proto_err != 0) begin
        fails++; $display("FAIL rand%0d_done done_cnt=%0d lag_ok=%0d proto_err=%0d exp 1/1/0", t, done_cnt, done_lag_ok, proto_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    int fed, cyc, bad;
    fed = 0; cyc = 0; bad = 0;
    @(negedge clk);
    cfg_num_ch = 8'd3; cfg_num_pix = 4; cfg_shift = '0; cfg_relu = 1'b0; bias = 0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    while (fed < 6 && cyc < 50) begin
      in_valid = 1'b1; in_data = 32'sd1000 + fed;
      #1;
      if (in_ready) fed++;
      @(negedge clk); cyc++;
    end
    checks++; if (fed != 6) begin fails++; $display("FAIL rstmid_feed got=%0d beats exp=6", fed); end
    in_valid = 1'b0; rst = 1'b1; #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0 || out_data !== 16'sd0) begin
      fails++; $display("FAIL rstmid_clear flags=%b data=%0d exp flags=0000 data=0", {in_ready, out_valid, busy, done}, out_data);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; if (done || out_valid || busy) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL rstmid_nodone got=%0d stray cycles exp=0", bad); end
    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(int'($urandom_range(0, 4000)) - 2000);
    model(2, 5, 0, 0, 1);
    run_plane(2, 5, 0, 0, 1, 0, 0, -1);
    checks++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL rstmid_fresh_count got=%0d exp=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_fresh_pix%0d got=%0d exp=%0d", i, got[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_requant();
    test_neg_sat();
    test_backpressure();
    test_cfg_edges();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
